sram_axi_arbiter: RTL
=====================

# sram_axi_arbiter

Parametrised NUM_PORT-to-one bridge from SRAM-like request ports to a single AXI3 master, replacing the fixed two-port (inst/data) bridge used today. Independent read and write channels, each with its own round-robin arbiter and one transaction in flight, so a read from one port overlaps a write from another. Supports INCR bursts of up to 256 beats per request and blocks a port's reads while its own write is unacknowledged, which enforces read-after-write ordering. Sits between the core/cache ports and the SoC AXI interconnect.

## Interface
- NUM_PORT, 2, number of request ports (1..16); port index is the AXI ID
- ADDR_W, 32, address width
- DATA_W, 32, data width (AXI beat width)

Ports (vectors are port-packed; port i occupies slice [i*W +: W]):
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- p_req  in  NUM_PORT  request valid, held until p_addr_ok
- p_wr  in  NUM_PORT  1 = write
- p_size  in  3*NUM_PORT  AXI size code
- p_len  in  8*NUM_PORT  beats-1
- p_addr  in  ADDR_W*NUM_PORT  start address
- p_wstrb  in  (DATA_W/8)*NUM_PORT  byte strobes, all beats
- p_wdata  in  DATA_W*NUM_PORT  current write beat; advance on p_wnext
- p_addr_ok  out  NUM_PORT  request accepted (1-cycle pulse)
- p_wnext  out  NUM_PORT  current write beat consumed (pulse)
- p_data_ok  out  NUM_PORT  read beat valid / write acknowledged (pulse)
- p_last  out  NUM_PORT  with p_data_ok: final read beat, or write response
- p_err  out  NUM_PORT  with p_data_ok: rresp/bresp != OKAY
- p_rdata  out  DATA_W  read beat data (shared; qualify with p_data_ok)
- AXI master: arid/awid/wid 4, araddr/awaddr ADDR_W, arlen/awlen 8, arsize/awsize 3, arburst/awburst 2, arlock/awlock 2, arcache/awcache 4, arprot/awprot 3, arvalid/awvalid, arready/awready in, rid/bid 4 in, rdata in DATA_W, rresp/bresp 2 in, rlast/rvalid in, rready, wdata DATA_W, wstrb DATA_W/8, wlast, wvalid, wready in, bvalid in, bready

## Operation
- Constants: ar/awburst=2'b01 (INCR), lock/cache/prot=0. ID = grant index, zero-extended.
- Read FSM R_IDLE→R_AR→R_DATA→R_IDLE. Eligible: p_req & ~p_wr & ~wpend[i]. In R_IDLE, pick first eligible at or after rr_rd (wrapping), latch owner/addr/len/size, go R_AR. R_AR: arvalid=1, fields stable; on arready, p_addr_ok[owner] pulses, go R_DATA. R_DATA: rready=1; each rvalid beat → p_data_ok[owner], p_rdata=rdata, p_err=(rresp!=0), p_last=rlast; on rlast go R_IDLE, rr_rd=owner+1 mod NUM_PORT. Routing uses latched owner, not rid.
- Write FSM W_IDLE→W_AW→W_DATA→W_RESP→W_IDLE. Eligible: p_req & p_wr. Same round-robin with rr_wr. W_AW: awvalid=1; on awready, p_addr_ok pulses, wpend[owner]=1, beat counter=0, go W_DATA. W_DATA: wvalid=1, wdata/wstrb from owner port, wlast=(cnt==len); each wvalid&wready → p_wnext[owner], cnt+1; after last beat go W_RESP. W_RESP: bready=1; on bvalid → p_data_ok, p_last, p_err=(bresp!=0) for owner, wpend cleared, rr_wr=owner+1, go W_IDLE.
- Same-cycle read and write grants to different ports both proceed. Port with req&wr never considered by read arbiter and vice versa.
- A port whose p_req drops before grant is simply skipped; after grant, dropping p_req has no effect.

## Timing
- Reset (async): all FSMs IDLE, rr_rd=rr_wr=0, wpend=0, every valid/ready/pulse output 0, address/data outputs 0.
- Grant: arvalid/awvalid rise the cycle after p_req seen in IDLE (1-cycle latency).
- p_addr_ok is combinational-free: registered pulse in the cycle after AR/AW handshake.
- p_data_ok/p_rdata/p_last/p_err registered: one cycle after the R or B beat. p_wnext is combinational with the W handshake.
- Back-to-back: return to IDLE then new grant; min 1 idle cycle between transactions per channel.
- arvalid/awvalid/wvalid never drop before their ready.
- len=0: single beat, wlast on first beat. len=255: 256 beats, counter 8 bits, no overflow.
- Reset mid-burst abandons the transaction; no outputs pulse afterwards.

## Test plan
- Single read, port 1, addr 0x1fc0_0000, len 3, arready delayed 2 cycles → arid=1, arlen=3, p_addr_ok[1] once, 4 p_data_ok[1], p_last only on 4th.
- Ports 0,1 both reading continuously → grants alternate 0,1,0,1; no port granted twice in a row.
- Port 0 write len 0 while port 1 reads → AW and AR overlap; wlast on only beat; p_data_ok[0]&p_last on B.
- Port 0 write pending (no bvalid 20 cycles), port 0 then issues read → no arvalid until 1 cycle after B accepted.
- bresp=2'b10 → p_err[owner]=1 with p_data_ok; rresp=0 → p_err=0.
- Assert reset during R_DATA beat 2 of 8 → all outputs 0 next edge; fresh read afterwards completes normally with NUM_PORT=4 build.

Source files
------------

// File: rtl/sram_axi_arbiter.sv
// sram_axi_arbiter: NUM_PORT SRAM-like request ports onto one AXI3 master.
// Independent round-robin read and write channels, one transaction each.
module sram_axi_arbiter #(
  parameter int NUM_PORT = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PORT-1:0]          p_req,
  input  logic [NUM_PORT-1:0]          p_wr,
  input  logic [3*NUM_PORT-1:0]        p_size,
  input  logic [8*NUM_PORT-1:0]        p_len,
  input  logic [ADDR_W*NUM_PORT-1:0]   p_addr,
  input  logic [DATA_W/8*NUM_PORT-1:0] p_wstrb,
  input  logic [DATA_W*NUM_PORT-1:0]   p_wdata,
  output logic [NUM_PORT-1:0]          p_addr_ok,
  output logic [NUM_PORT-1:0]          p_wnext,
  output logic [NUM_PORT-1:0]          p_data_ok,
  output logic [NUM_PORT-1:0]          p_last,
  output logic [NUM_PORT-1:0]          p_err,
  output logic [DATA_W-1:0]            p_rdata,
  output logic [3:0]                   arid,
  output logic [ADDR_W-1:0]            araddr,
  output logic [7:0]                   arlen,
  output logic [2:0]                   arsize,
  output logic [1:0]                   arburst,
  output logic [1:0]                   arlock,
  output logic [3:0]                   arcache,
  output logic [2:0]                   arprot,
  output logic                         arvalid,
  input  logic                         arready,
  input  logic [3:0]                   rid,
  input  logic [DATA_W-1:0]            rdata,
  input  logic [1:0]                   rresp,
  input  logic                         rlast,
  input  logic                         rvalid,
  output logic                         rready,
  output logic [3:0]                   awid,
  output logic [ADDR_W-1:0]            awaddr,
  output logic [7:0]                   awlen,
  output logic [2:0]                   awsize,
  output logic [1:0]                   awburst,
  output logic [1:0]                   awlock,
  output logic [3:0]                   awcache,
  output logic [2:0]                   awprot,
  output logic                         awvalid,
  input  logic                         awready,
  output logic [3:0]                   wid,
  output logic [DATA_W-1:0]            wdata,
  output logic [DATA_W/8-1:0]          wstrb,
  output logic                         wlast,
  output logic                         wvalid,
  input  logic                         wready,
  input  logic [3:0]                   bid,
  input  logic [1:0]                   bresp,
  input  logic                         bvalid,
  output logic                         bready
);
  localparam int SW = DATA_W / 8;
  localparam int IW = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_AR   = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_AW   = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  function automatic logic [IW-1:0] wrap(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_PORT) s = s - NUM_PORT;
    return IW'(s);
  endfunction

  function automatic logic [IW-1:0] next_rr(input logic [IW-1:0] o);
    return (int'(o) == NUM_PORT - 1) ? '0 : o + 1'b1;
  endfunction

  logic [1:0]          rstate_q, rstate_d, wstate_q, wstate_d;
  logic [IW-1:0]       rowner_q, rowner_d, wowner_q, wowner_d;
  logic [IW-1:0]       rr_rd_q, rr_rd_d, rr_wr_q, rr_wr_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d, waddr_q, waddr_d;
  logic [7:0]          rlen_q, rlen_d, wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [2:0]          rsize_q, rsize_d, wsize_q, wsize_d;
  logic [NUM_PORT-1:0] wpend_q, wpend_d;
  logic [NUM_PORT-1:0] aok_q, aok_d, dok_q, dok_d;
  logic [NUM_PORT-1:0] last_q, last_d, err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [NUM_PORT-1:0] rd_elig, wr_elig;
  logic [NUM_PORT-1:0] rd_aok, rd_dok, rd_last, rd_err;
  logic [NUM_PORT-1:0] wr_aok, wr_dok, wr_last, wr_err, wr_next;
  logic                rd_hit, wr_hit;
  logic [IW-1:0]       rd_pick, wr_pick;
  logic                unused_ids;

  assign unused_ids = ^{rid, bid};
  assign rd_elig = p_req & ~p_wr & ~wpend_q;
  assign wr_elig = p_req & p_wr;

  // Round-robin pick: first eligible port at or after the pointer.
  always_comb begin
    rd_hit  = 1'b0;
    rd_pick = rr_rd_q;
    wr_hit  = 1'b0;
    wr_pick = rr_wr_q;
    for (int k = 0; k < NUM_PORT; k++) begin
      if (!rd_hit && rd_elig[wrap(rr_rd_q, k)]) begin
        rd_hit  = 1'b1;
        rd_pick = wrap(rr_rd_q, k);
      end
      if (!wr_hit && wr_elig[wrap(rr_wr_q, k)]) begin
        wr_hit  = 1'b1;
        wr_pick = wrap(rr_wr_q, k);
      end
    end
  end

  // Read channel FSM; beats are routed by latched owner, not rid.
  always_comb begin
    rstate_d = rstate_q;
    rowner_d = rowner_q;
    raddr_d  = raddr_q;
    rlen_d   = rlen_q;
    rsize_d  = rsize_q;
    rr_rd_d  = rr_rd_q;
    rd_aok   = '0;
    rd_dok   = '0;
    rd_last  = '0;
    rd_err   = '0;
    case (rstate_q)
      R_IDLE: if (rd_hit) begin
        rowner_d = rd_pick;
        raddr_d  = p_addr[rd_pick*ADDR_W +: ADDR_W];
        rlen_d   = p_len[rd_pick*8 +: 8];
        rsize_d  = p_size[rd_pick*3 +: 3];
        rstate_d = R_AR;
      end
      R_AR: if (arready) begin
        rd_aok[rowner_q] = 1'b1;
        rstate_d = R_DATA;
      end
      R_DATA: if (rvalid) begin
        rd_dok[rowner_q]  = 1'b1;
        rd_last[rowner_q] = rlast;
        rd_err[rowner_q]  = (rresp != 2'b00);
        if (rlast) begin
          rstate_d = R_IDLE;
          rr_rd_d  = next_rr(rowner_q);
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Write channel FSM; wpend blocks the owner's reads until B returns.
  always_comb begin
    wstate_d = wstate_q;
    wowner_d = wowner_q;
    waddr_d  = waddr_q;
    wlen_d   = wlen_q;
    wsize_d  = wsize_q;
    wcnt_d   = wcnt_q;
    rr_wr_d  = rr_wr_q;
    wpend_d  = wpend_q;
    wr_aok   = '0;
    wr_dok   = '0;
    wr_last  = '0;
    wr_err   = '0;
    wr_next  = '0;
    case (wstate_q)
      W_IDLE: if (wr_hit) begin
        wowner_d = wr_pick;
        waddr_d  = p_addr[wr_pick*ADDR_W +: ADDR_W];
        wlen_d   = p_len[wr_pick*8 +: 8];
        wsize_d  = p_size[wr_pick*3 +: 3];
        wstate_d = W_AW;
      end
      W_AW: if (awready) begin
        wr_aok[wowner_q]  = 1'b1;
        wpend_d[wowner_q] = 1'b1;
        wcnt_d   = '0;
        wstate_d = W_DATA;
      end
      W_DATA: if (wready) begin
        wr_next[wowner_q] = 1'b1;
        if (wcnt_q == wlen_q) wstate_d = W_RESP;
        else wcnt_d = wcnt_q + 8'd1;
      end
      default: if (bvalid) begin
        wr_dok[wowner_q]  = 1'b1;
        wr_last[wowner_q] = 1'b1;
        wr_err[wowner_q]  = (bresp != 2'b00);
        wpend_d[wowner_q] = 1'b0;
        rr_wr_d  = next_rr(wowner_q);
        wstate_d = W_IDLE;
      end
    endcase
  end

  // Merge per-channel pulses into the registered port outputs.
  always_comb begin
    aok_d   = rd_aok | wr_aok;
    dok_d   = rd_dok | wr_dok;
    last_d  = rd_last | wr_last;
    err_d   = rd_err | wr_err;
    rdata_d = (rstate_q == R_DATA && rvalid) ? rdata : rdata_q;
  end

  // Read channel state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rstate_q <= R_IDLE;
      rowner_q <= '0;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rsize_q  <= '0;
      rr_rd_q  <= '0;
    end else begin
      rstate_q <= rstate_d;
      rowner_q <= rowner_d;
      raddr_q  <= raddr_d;
      rlen_q   <= rlen_d;
      rsize_q  <= rsize_d;
      rr_rd_q  <= rr_rd_d;
    end
  end

  // Write channel state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wstate_q <= W_IDLE;
      wowner_q <= '0;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wsize_q  <= '0;
      wcnt_q   <= '0;
      rr_wr_q  <= '0;
      wpend_q  <= '0;
    end else begin
      wstate_q <= wstate_d;
      wowner_q <= wowner_d;
      waddr_q  <= waddr_d;
      wlen_q   <= wlen_d;
      wsize_q  <= wsize_d;
      wcnt_q   <= wcnt_d;
      rr_wr_q  <= rr_wr_d;
      wpend_q  <= wpend_d;
    end
  end

  // Registered port-side pulses and read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aok_q   <= '0;
      dok_q   <= '0;
      last_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      aok_q   <= aok_d;
      dok_q   <= dok_d;
      last_q  <= last_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign p_addr_ok = aok_q;
  assign p_data_ok = dok_q;
  assign p_last    = last_q;
  assign p_err     = err_q;
  assign p_rdata   = rdata_q;
  assign p_wnext   = wr_next;

  assign arid    = 4'(rowner_q);
  assign araddr  = raddr_q;
  assign arlen   = rlen_q;
  assign arsize  = rsize_q;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = (rstate_q == R_AR);
  assign rready  = (rstate_q == R_DATA);

  assign awid    = 4'(wowner_q);
  assign awaddr  = waddr_q;
  assign awlen   = wlen_q;
  assign awsize  = wsize_q;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign awvalid = (wstate_q == W_AW);
  assign wid     = 4'(wowner_q);
  assign wvalid  = (wstate_q == W_DATA);
  assign wdata   = wvalid ? p_wdata[wowner_q*DATA_W +: DATA_W] : '0;
  assign wstrb   = wvalid ? p_wstrb[wowner_q*SW +: SW] : '0;
  assign wlast   = wvalid && (wcnt_q == wlen_q);
  assign bready  = (wstate_q == W_RESP);

endmodule
